fifo_stream_reader: RTL and testbench

- Read-side controller for the team's synchronous FIFO.
- Monitors the FIFO's empty flag and issues read_en pulses without ever causing underflow.
- Absorbs the FIFO's 1-cycle registered read latency in a 2-entry output buffer.
- Presents words on a valid/ready stream to the downstream consumer at up to 1 word/cycle, with enable, flush and error reporting.

---
 rtl/fifo_stream_reader.sv | 179 +++++++++++++++++
 tb/tb_fifo_stream_reader.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader
// Read-side controller for the team's synchronous FIFO. It watches fifo_empty,
// pops words with fifo_read_en without ever underflowing the FIFO, absorbs the
// FIFO's one-cycle registered read latency in a 2-entry output buffer, and
// presents the words on a valid/ready stream at up to one word per cycle.
//
// Ports:
//   clk, reset       single clock; synchronous active-high reset
//   enable           permits new FIFO reads (IDLE <-> RUN)
//   flush            discards buffered and FIFO contents while high
//   fifo_empty       FIFO empty flag
//   fifo_underflow   FIFO underflow flag (latched into err_underflow)
//   fifo_data_out    FIFO read data, valid the cycle after fifo_read_en
//   fifo_read_en     FIFO pop request
//   m_valid/m_data   stream output, m_ready from the consumer
//   busy             state not IDLE, or buffered / in-flight words present
//   err_underflow    sticky underflow error, cleared only by reset
//   word_count       accepted-word count (statistics build only)
//   stall_count      back-pressure cycle count (statistics build only)
//
// Build option: define FIFO_READER_STATS_EN to add the saturating 32-bit
// word_count / stall_count counters. Without it both ports read as zero and
// no counter flops exist.
module fifo_stream_reader #(
    parameter int DATA_WIDTH      = 8,
    parameter int FIFO_RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  flush,
    input  logic                  fifo_empty,
    input  logic                  fifo_underflow,
    input  logic [DATA_WIDTH-1:0] fifo_data_out,
    output logic                  fifo_read_en,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic                  busy,
    output logic                  err_underflow,
    output logic [31:0]           word_count,
    output logic [31:0]           stall_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            occ_q, occ_d;
    logic                  inflight_q, inflight_d;
    logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
    logic [DATA_WIDTH-1:0] buf1_q, buf1_d;
    logic                  err_q, err_d;

    logic       pop;
    logic       capture;
    logic [1:0] occ_after_pop;
    logic [2:0] occ_sum;

    // buf0 is always the head of the buffer, buf1 the second word.
    assign m_valid       = (occ_q != 2'd0) && (state_q != FLUSH);
    assign m_data        = buf0_q;
    assign busy          = (state_q != IDLE) || (occ_q != 2'd0) || inflight_q;
    assign err_underflow = err_q;

    always_comb begin
        pop           = m_valid & m_ready;
        // Words returning while flushing are thrown away instead of stored.
        capture       = inflight_q && (state_q != FLUSH);
        occ_after_pop = occ_q - {1'b0, pop};
        occ_sum       = {1'b0, occ_q} + {2'b00, capture} - {2'b00, pop};

        // In RUN, capture equals inflight, so occ_sum is exactly the
        // occupancy the buffer will hold once this cycle's word lands; a new
        // read is only safe if that still leaves room for it next cycle.
        fifo_read_en = 1'b0;
        case (state_q)
            RUN:     fifo_read_en = !fifo_empty && (occ_sum < 3'd2);
            FLUSH:   fifo_read_en = !fifo_empty;
            default: fifo_read_en = 1'b0;
        endcase

        inflight_d = fifo_read_en;
        err_d      = err_q | fifo_underflow;

        state_d = state_q;
        if (flush) begin
            state_d = FLUSH;
        end else begin
            case (state_q)
                IDLE:    if (enable) state_d = RUN;
                RUN:     if (!enable) state_d = IDLE;
                FLUSH:   if (fifo_empty && !inflight_q) state_d = enable ? RUN : IDLE;
                default: state_d = IDLE;
            endcase
        end

        occ_d = flush ? 2'd0 : occ_sum[1:0];

        // Popping shifts the second word to the head; a captured word then
        // goes to whichever slot is the tail after that shift.
        buf0_d = buf0_q;
        buf1_d = buf1_q;
        if (pop) begin
            buf0_d = buf1_q;
        end
        if (capture) begin
            if (occ_after_pop == 2'd0) begin
                buf0_d = fifo_data_out;
            end else begin
                buf1_d = fifo_data_out;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            buf0_q     <= '0;
            buf1_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
            err_q      <= err_d;
        end
    end

    // The read-issue rule must keep the 2-entry buffer from overflowing, and
    // the capture timing assumes a one-cycle FIFO read latency.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (occ_sum <= 3'd2);
            assert (FIFO_RD_LATENCY == 1);
        end
    end

`ifdef FIFO_READER_STATS_EN
    logic [31:0] word_count_q, word_count_d;
    logic [31:0] stall_count_q, stall_count_d;

    // Both counters stick at all-ones rather than wrapping.
    always_comb begin
        word_count_d  = word_count_q;
        stall_count_d = stall_count_q;
        if (pop && (word_count_q != 32'hFFFF_FFFF)) begin
            word_count_d = word_count_q + 32'd1;
        end
        if (m_valid && !m_ready && (stall_count_q != 32'hFFFF_FFFF)) begin
            stall_count_d = stall_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            word_count_q  <= 32'd0;
            stall_count_q <= 32'd0;
        end else begin
            word_count_q  <= word_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign word_count  = word_count_q;
    assign stall_count = stall_count_q;
`else
    assign word_count  = 32'd0;
    assign stall_count = 32'd0;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader
// Self-checking bench for fifo_stream_reader. A behavioural FIFO with one
// cycle of read latency feeds the reader; a scoreboard queue holds every word
// written into the FIFO and each accepted stream word must match its head.
// A flush discards everything not yet accepted, a reset discards everything.
module tb_fifo_stream_reader;

    localparam int DW = 8;
`ifdef FIFO_READER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          flush;
    logic          fifo_empty;
    logic          fifo_underflow;
    logic [DW-1:0] fifo_data_out;
    logic          fifo_read_en;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_ready;
    logic          busy;
    logic          err_underflow;
    logic [31:0]   word_count;
    logic [31:0]   stall_count;

    fifo_stream_reader #(
        .DATA_WIDTH      (DW),
        .FIFO_RD_LATENCY (1)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .flush          (flush),
        .fifo_empty     (fifo_empty),
        .fifo_underflow (fifo_underflow),
        .fifo_data_out  (fifo_data_out),
        .fifo_read_en   (fifo_read_en),
        .m_valid        (m_valid),
        .m_data         (m_data),
        .m_ready        (m_ready),
        .busy           (busy),
        .err_underflow  (err_underflow),
        .word_count     (word_count),
        .stall_count    (stall_count)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] sb_q[$];
    int            pop_log[$];
    int            compared_cnt  = 0;
    int            mismatched_cnt = 0;
    int            cycle_no = 0;
    int            rd_count = 0;
    int            pop_count = 0;
    int            model_words = 0;
    int            model_stalls = 0;
    logic          hold_prev = 1'b0;
    logic [DW-1:0] prev_data = '0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared_cnt++;
        if (observed !== expected) begin
            mismatched_cnt++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, observed, expected, cycle_no);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic rdy, input logic fl);
        enable  = en;
        m_ready = rdy;
        flush   = fl;
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        fifo_q.push_back(w);
        sb_q.push_back(w);
        fifo_empty <= 1'b0;
    endtask

    // Checks made just before each rising edge, on stable outputs.
    task automatic monitor();
        logic [DW-1:0] exp_w;
        checkOutput("rd_while_empty", {31'd0, fifo_read_en & fifo_empty}, 32'd0);
        if (hold_prev) begin
            checkOutput("hold_valid", {31'd0, m_valid}, 32'd1);
            checkOutput("hold_data", {24'd0, m_data}, {24'd0, prev_data});
        end
        if (reset) begin
            sb_q.delete();
            model_words  = 0;
            model_stalls = 0;
            hold_prev    = 1'b0;
        end else begin
            if (m_valid && m_ready) begin
                if (sb_q.size() == 0) begin
                    checkOutput("unexpected_word", 32'd1, 32'd0);
                end else begin
                    exp_w = sb_q.pop_front();
                    checkOutput("stream_data", {24'd0, m_data}, {24'd0, exp_w});
                end
                pop_count++;
                model_words++;
                pop_log.push_back(cycle_no);
            end
            if (m_valid && !m_ready) begin
                model_stalls++;
            end
            hold_prev = m_valid && !m_ready && !flush;
            prev_data = m_data;
            if (flush) begin
                sb_q.delete();
            end
        end
    endtask

    // Behavioural FIFO: a pop at the edge returns data one cycle later;
    // when not read the data bus carries junk.
    task automatic fifo_model();
        logic [DW-1:0] w;
        if (fifo_read_en && (fifo_q.size() != 0)) begin
            w = fifo_q.pop_front();
            fifo_data_out <= w;
            rd_count++;
        end else begin
            fifo_data_out <= DW'($urandom);
        end
        fifo_empty <= (fifo_q.size() == 0);
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        fifo_model();
        cycle_no++;
        #1;
    endtask

    task automatic applyReset();
        reset = 1'b1;
        tick();
        fifo_q.delete();
        fifo_empty <= 1'b1;
        reset = 1'b0;
    endtask

    task automatic drain(input string tag, input int limit);
        for (int i = 0; i < limit && (sb_q.size() != 0); i++) begin
            tick();
        end
        checkOutput(tag, sb_q.size(), 32'd0);
    endtask

    task automatic wait_valid(input string tag, input int limit);
        for (int i = 0; i < limit && !m_valid; i++) begin
            tick();
        end
        checkOutput(tag, {31'd0, m_valid}, 32'd1);
    endtask

    initial begin
        int span;
        int flush_hold;
        fifo_empty     <= 1'b1;
        fifo_data_out  <= '0;
        fifo_underflow = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        tick();
        tick();
        applyReset();

        // Reset values
        checkOutput("rst_m_valid", {31'd0, m_valid}, 32'd0);
        checkOutput("rst_m_data", {24'd0, m_data}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_read_en", {31'd0, fifo_read_en}, 32'd0);
        checkOutput("rst_err", {31'd0, err_underflow}, 32'd0);

        // Burst read of a preloaded FIFO
        for (int i = 1; i <= 8; i++) begin
            push_word(DW'(i));
        end
        tick();
        checkOutput("idle_no_read", rd_count, 32'd0);
        pop_log.delete();
        applyStimulus(1'b1, 1'b1, 1'b0);
        drain("burst_drained", 40);
        span = (pop_log.size() == 8) ? (pop_log[7] - pop_log[0]) : -1;
        checkOutput("burst_count", pop_log.size(), 32'd8);
        checkOutput("burst_span", span, 32'd7);
        tick();
        checkOutput("burst_read_en_low", {31'd0, fifo_read_en}, 32'd0);
        checkOutput("burst_err", {31'd0, err_underflow}, 32'd0);

        // Back-pressure
        applyReset();
        applyStimulus(1'b1, 1'b0, 1'b0);
        tick();
        tick();
        rd_count = 0;
        for (int i = 0; i < 6; i++) begin
            push_word(DW'(8'hA0 + i));
        end
        wait_valid("bp_valid", 10);
        repeat (10) tick();
        checkOutput("bp_reads", rd_count, 32'd2);
        checkOutput("bp_head", {24'd0, m_data}, 32'h0000_00A0);
        checkOutput("bp_stalls_model", model_stalls, 32'd10);
        checkOutput("bp_stall_count", stall_count, STATS ? 32'(model_stalls) : 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        drain("bp_drained", 40);
        tick();
        checkOutput("bp_word_count", word_count, STATS ? 32'(model_words) : 32'd0);

        // Enable drops the cycle after a read
        rd_count  = 0;
        pop_count = 0;
        for (int i = 0; i < 3; i++) begin
            push_word(DW'(8'h30 + i));
        end
        tick();
        applyStimulus(1'b0, 1'b1, 1'b0);
        repeat (8) tick();
        checkOutput("endrop_reads", rd_count, 32'd2);
        checkOutput("endrop_delivered", pop_count, 32'd2);
        checkOutput("endrop_busy", {31'd0, busy}, 32'd0);
        checkOutput("endrop_left", fifo_q.size(), 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b0);
        drain("endrop_drained", 20);

        // Flush with a full output buffer
        applyStimulus(1'b1, 1'b0, 1'b0);
        tick();
        rd_count = 0;
        for (int i = 0; i < 7; i++) begin
            push_word(DW'(8'hC0 + i));
        end
        wait_valid("fl_valid", 10);
        repeat (3) tick();
        checkOutput("fl_pre_reads", rd_count, 32'd2);
        applyStimulus(1'b1, 1'b0, 1'b1);
        tick();
        checkOutput("fl_m_valid", {31'd0, m_valid}, 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 20 && (fifo_q.size() != 0); i++) begin
            tick();
        end
        repeat (3) tick();
        checkOutput("fl_fifo_emptied", fifo_q.size(), 32'd0);
        checkOutput("fl_no_output", {31'd0, m_valid}, 32'd0);
        push_word(8'h5A);
        drain("fl_resume", 20);

        // Underflow flag is sticky
        fifo_underflow = 1'b1;
        tick();
        fifo_underflow = 1'b0;
        checkOutput("uf_set", {31'd0, err_underflow}, 32'd1);
        repeat (5) tick();
        checkOutput("uf_sticky", {31'd0, err_underflow}, 32'd1);

        // Reset in the middle of a stream
        applyStimulus(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            push_word(DW'($urandom));
        end
        repeat (3) tick();
        applyReset();
        checkOutput("mr_m_valid", {31'd0, m_valid}, 32'd0);
        checkOutput("mr_read_en", {31'd0, fifo_read_en}, 32'd0);
        checkOutput("mr_m_data", {24'd0, m_data}, 32'd0);
        checkOutput("mr_busy", {31'd0, busy}, 32'd0);
        checkOutput("mr_err", {31'd0, err_underflow}, 32'd0);
        checkOutput("mr_word_count", word_count, 32'd0);
        checkOutput("mr_stall_count", stall_count, 32'd0);

        // Randomized traffic
        applyStimulus(1'b1, 1'b1, 1'b0);
        flush_hold = 0;
        for (int c = 0; c < 2000; c++) begin
            flush = 1'b0;
            if ((flush_hold > 0) && (fifo_q.size() == 0)) begin
                flush_hold--;
            end
            if ((flush_hold == 0) && ($urandom_range(0, 99) < 2)) begin
                flush      = 1'b1;
                flush_hold = 3;
            end else if ((flush_hold == 0) && (fifo_q.size() < 12) && ($urandom_range(0, 99) < 45)) begin
                push_word(DW'($urandom));
            end
            m_ready = ($urandom_range(0, 99) < 70);
            if ($urandom_range(0, 99) < 5) begin
                enable = !enable;
            end
            tick();
        end
        applyStimulus(1'b1, 1'b1, 1'b0);
        drain("rand_drained", 300);
        tick();
        checkOutput("rand_word_count", word_count, STATS ? 32'(model_words) : 32'd0);
        checkOutput("rand_stall_count", stall_count, STATS ? 32'(model_stalls) : 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        repeat (3) tick();
        checkOutput("rand_idle_busy", {31'd0, busy}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared_cnt, mismatched_cnt);
        $finish;
    end

endmodule
